jbi_sc_req_arb: RTL and testbench
=================================

# jbi_sc_req_arb

Request scheduler for the JBI-to-L2 (sctag/scbuf) request path. It arbitrates between the JBI read-request queue and write-request queue. It streams the granted packet one 32-bit word per cycle onto the registered request bus that feeds the JBI–sctag flop stage. It also tracks the sctag input-queue (IQ) and write-invalidate-buffer (WIB) credits so that no request is ever issued that the sctag cannot accept.

## Interface
Parameters:
- IQ_DEPTH, 16, sctag IQ entries, which is the initial and maximum IQ credit count (range 1–31).
- WIB_DEPTH, 4, sctag WIB entries, which is the initial and maximum WIB credit count (range 1–15).

Ports:
- rclk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- rd_vld  in  1  read queue has a complete 2-word packet ready.
- rd_data  in  32  current read-packet word.
- rd_ack  out  1  read word taken this cycle; the queue advances to the next word.
- wr_vld  in  1  write queue has a complete 18-word packet ready.
- wr_data  in  32  current write-packet word.
- wr_ecc  in  7  ECC for the current write data word.
- wr_ack  out  1  write word taken this cycle.
- sctag_jbi_iq_dequeue  in  1  one IQ credit returned.
- sctag_jbi_wib_dequeue  in  1  one WIB credit returned.
- jbi_sctag_req  out  32  registered request word.
- jbi_sctag_req_vld  out  1  registered; high on the first word of each packet only.
- jbi_scbuf_ecc  out  7  registered ECC for the word on jbi_sctag_req.
- cred_err  out  1  sticky credit overflow flag.

## Operation
- The FSM has three states: IDLE, RD, WR. The reset state is IDLE.
- Eligibility, evaluated in IDLE only:
  - Read is eligible when rd_vld is high and iq_cred > 0.
  - Write is eligible when wr_vld is high, iq_cred > 0 and wib_cred > 0.
- Arbitration:
  - If only one requester is eligible, it is granted.
  - If both are eligible, a round-robin pointer picks. The pointer resets to favour read, and it flips to the other requester after every grant.
- On a grant, the FSM goes IDLE→RD or IDLE→WR.
  - The grant decrements iq_cred by 1.
  - A write grant also decrements wib_cred by 1.
  - No ack is issued in the grant cycle.
- RD lasts exactly 2 cycles (beat 0 = header, beat 1 = address).
  - rd_ack is high in both cycles.
  - rd_data is captured into jbi_sctag_req.
  - ECC is driven as 7'h0.
- WR lasts exactly 18 cycles (beats 0–1 = header/address, beats 2–17 = data).
  - wr_ack is high in every cycle.
  - wr_data is captured.
  - wr_ecc is captured on beats 2–17; ECC is driven as 7'h0 on beats 0–1.
- jbi_sctag_req_vld is captured as 1 on beat 0 only.
- After the last beat, the FSM returns to IDLE. Packets are therefore separated by at least one idle cycle.
- Beat counter: 5 bits, cleared on every grant.
- Credit counters:
  - A dequeue increments its counter by 1.
  - When a grant and a dequeue of the same credit type occur in the same cycle, the counter is unchanged.
  - A dequeue with the counter already at its maximum leaves the counter at the maximum and sets cred_err. cred_err clears only on reset.
- rd_vld/wr_vld are not sampled during RD/WR. The requester must supply one valid word in every acked cycle.

## Timing
- Reset values:
  - State is IDLE; iq_cred = IQ_DEPTH; wib_cred = WIB_DEPTH.
  - rd_ack = wr_ack = 0.
  - jbi_sctag_req = 0, jbi_sctag_req_vld = 0, jbi_scbuf_ecc = 0, cred_err = 0.
- rd_ack and wr_ack are combinational decodes of state.
- The request outputs are registered. A word acked in cycle N appears on jbi_sctag_req in cycle N+1.
- Latency from valid to request: a requester valid in IDLE at cycle T gives a grant at edge T, ack at T+1, and jbi_sctag_req_vld high at T+2.
- Minimum packet spacing, measured vld-to-vld:
  - 3 cycles after a read.
  - 19 cycles after a write.
- A dequeue in cycle N is visible to eligibility in cycle N+1.
- Reset asserted mid-packet aborts the packet immediately and restores all reset values. The requester queues must be reset by the same rst.

## Configuration
- JBI_SC_ARB_PERF_EN defined:
  - Adds outputs perf_rd_cnt[15:0] and perf_wr_cnt[15:0].
  - Each counter increments on every read or write grant respectively.
  - Each saturates at 16'hFFFF and resets to 0.
- JBI_SC_ARB_PERF_EN undefined: the ports and logic are absent, and all other behaviour is identical.

## Test plan
- Single read: after reset, rd_vld=1 with rd_data 32'hA0000001/32'h00001000. Required response:
  - jbi_sctag_req_vld is high only in cycle T+2, carrying A0000001.
  - 00001000 follows at T+3.
  - ECC is 0.
  - iq_cred goes to 15.
- Single write: 18 words with data words carrying wr_ecc=7'h55. Required response:
  - vld is high on the first word only.
  - 16 data beats carry ECC 55.
  - wib_cred goes 4→3.
  - Exactly 18 wr_ack cycles.
- Contention: rd_vld and wr_vld both held high. Required grants are read, write, read, write, and so on. After 4 writes with no WIB dequeue, only reads are granted until one sctag_jbi_wib_dequeue pulse.
- Credit exhaustion: 16 reads with no IQ dequeue, then the requester keeps rd_vld high. Required response:
  - No further grant.
  - One iq_dequeue pulse gives exactly one more read.
  - A grant and a dequeue in the same cycle leave the count unchanged.
- Overflow and reset: an IQ dequeue at full credit sets cred_err with the count staying 16. Asserting rst at WR beat 7 gives, in the same cycle, IDLE, all outputs 0, and credits at 16/4.
- With JBI_SC_ARB_PERF_EN: 3 reads and 2 writes give perf_rd_cnt=3 and perf_wr_cnt=2.

Source files
------------

// File: rtl/jbi_sc_req_arb.sv
// JBI-to-sctag request scheduler: round-robin read/write arbitration with IQ/WIB credit tracking.
// Optional JBI_SC_ARB_PERF_EN adds saturating read/write grant counters.
module jbi_sc_req_arb #(
  parameter int unsigned IQ_DEPTH  = 16,
  parameter int unsigned WIB_DEPTH = 4
) (
  input  logic        rclk,
  input  logic        rst,
  input  logic        rd_vld,
  input  logic [31:0] rd_data,
  output logic        rd_ack,
  input  logic        wr_vld,
  input  logic [31:0] wr_data,
  input  logic [6:0]  wr_ecc,
  output logic        wr_ack,
  input  logic        sctag_jbi_iq_dequeue,
  input  logic        sctag_jbi_wib_dequeue,
  output logic [31:0] jbi_sctag_req,
  output logic        jbi_sctag_req_vld,
  output logic [6:0]  jbi_scbuf_ecc,
  output logic        cred_err
`ifdef JBI_SC_ARB_PERF_EN
  ,
  output logic [15:0] perf_rd_cnt,
  output logic [15:0] perf_wr_cnt
`endif
);

  localparam logic [4:0] IQ_MAX  = 5'(IQ_DEPTH);
  localparam logic [3:0] WIB_MAX = 4'(WIB_DEPTH);

  typedef enum logic [1:0] {IDLE, RD, WR} state_t;

  state_t     state;
  logic [4:0] beat;
  logic [4:0] iq_cred;
  logic [3:0] wib_cred;
  logic       rr_ptr;
  logic       rd_elig, wr_elig, grant_rd, grant_wr;
  logic       iq_take, wib_take;

  // rr_ptr = 0 favours read, 1 favours write
  always_comb begin
    rd_elig  = (state == IDLE) && rd_vld && (iq_cred != '0);
    wr_elig  = (state == IDLE) && wr_vld && (iq_cred != '0) && (wib_cred != '0);
    grant_rd = rd_elig && (!wr_elig || !rr_ptr);
    grant_wr = wr_elig && (!rd_elig || rr_ptr);
    iq_take  = grant_rd || grant_wr;
    wib_take = grant_wr;
  end

  assign rd_ack = (state == RD);
  assign wr_ack = (state == WR);

  always_ff @(posedge rclk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      beat              <= '0;
      rr_ptr            <= 1'b0;
      jbi_sctag_req     <= '0;
      jbi_sctag_req_vld <= 1'b0;
      jbi_scbuf_ecc     <= '0;
    end else begin
      jbi_sctag_req     <= '0;
      jbi_sctag_req_vld <= 1'b0;
      jbi_scbuf_ecc     <= '0;
      unique case (state)
        IDLE: begin
          if (grant_rd) begin
            state  <= RD;
            beat   <= '0;
            rr_ptr <= 1'b1;
          end else if (grant_wr) begin
            state  <= WR;
            beat   <= '0;
            rr_ptr <= 1'b0;
          end
        end
        RD: begin
          jbi_sctag_req     <= rd_data;
          jbi_sctag_req_vld <= (beat == 5'd0);
          beat              <= beat + 5'd1;
          if (beat == 5'd1) state <= IDLE;
        end
        WR: begin
          jbi_sctag_req     <= wr_data;
          jbi_sctag_req_vld <= (beat == 5'd0);
          jbi_scbuf_ecc     <= (beat >= 5'd2) ? wr_ecc : '0;
          beat              <= beat + 5'd1;
          if (beat == 5'd17) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Simultaneous grant and dequeue of the same credit type cancel out.
  always_ff @(posedge rclk or posedge rst) begin
    if (rst) begin
      iq_cred  <= IQ_MAX;
      wib_cred <= WIB_MAX;
      cred_err <= 1'b0;
    end else begin
      unique case ({sctag_jbi_iq_dequeue, iq_take})
        2'b10: begin
          if (iq_cred == IQ_MAX) cred_err <= 1'b1;
          else                   iq_cred  <= iq_cred + 5'd1;
        end
        2'b01:   iq_cred <= iq_cred - 5'd1;
        default: iq_cred <= iq_cred;
      endcase
      unique case ({sctag_jbi_wib_dequeue, wib_take})
        2'b10: begin
          if (wib_cred == WIB_MAX) cred_err <= 1'b1;
          else                     wib_cred <= wib_cred + 4'd1;
        end
        2'b01:   wib_cred <= wib_cred - 4'd1;
        default: wib_cred <= wib_cred;
      endcase
    end
  end

`ifdef JBI_SC_ARB_PERF_EN
  always_ff @(posedge rclk or posedge rst) begin
    if (rst) begin
      perf_rd_cnt <= '0;
      perf_wr_cnt <= '0;
    end else begin
      if (grant_rd && (perf_rd_cnt != '1)) perf_rd_cnt <= perf_rd_cnt + 16'd1;
      if (grant_wr && (perf_wr_cnt != '1)) perf_wr_cnt <= perf_wr_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_jbi_sc_req_arb.sv
// Directed self-checking bench for jbi_sc_req_arb: single read/write, contention, credits, overflow, reset.
module tb_jbi_sc_req_arb;

  logic        rclk;
  logic        rst;
  logic        rd_vld;
  logic [31:0] rd_data;
  logic        rd_ack;
  logic        wr_vld;
  logic [31:0] wr_data;
  logic [6:0]  wr_ecc;
  logic        wr_ack;
  logic        sctag_jbi_iq_dequeue;
  logic        sctag_jbi_wib_dequeue;
  logic [31:0] jbi_sctag_req;
  logic        jbi_sctag_req_vld;
  logic [6:0]  jbi_scbuf_ecc;
  logic        cred_err;
`ifdef JBI_SC_ARB_PERF_EN
  logic [15:0] perf_rd_cnt;
  logic [15:0] perf_wr_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  jbi_sc_req_arb #(.IQ_DEPTH(16), .WIB_DEPTH(4)) dut (
    .rclk                  (rclk),
    .rst                   (rst),
    .rd_vld                (rd_vld),
    .rd_data               (rd_data),
    .rd_ack                (rd_ack),
    .wr_vld                (wr_vld),
    .wr_data               (wr_data),
    .wr_ecc                (wr_ecc),
    .wr_ack                (wr_ack),
    .sctag_jbi_iq_dequeue  (sctag_jbi_iq_dequeue),
    .sctag_jbi_wib_dequeue (sctag_jbi_wib_dequeue),
    .jbi_sctag_req         (jbi_sctag_req),
    .jbi_sctag_req_vld     (jbi_sctag_req_vld),
    .jbi_scbuf_ecc         (jbi_scbuf_ecc),
    .cred_err              (cred_err)
`ifdef JBI_SC_ARB_PERF_EN
    ,
    .perf_rd_cnt           (perf_rd_cnt),
    .perf_wr_cnt           (perf_wr_cnt)
`endif
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rd_vld = 1'b0;
    wr_vld = 1'b0;
    sctag_jbi_iq_dequeue = 1'b0;
    sctag_jbi_wib_dequeue = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // kind: 0 = read grant, 1 = write grant, 2 = no grant within the cycle budget
  task automatic next_grant(output int kind);
    logic busy_prev;
    kind = 2;
    for (int n = 0; n < 40; n++) begin
      busy_prev = rd_ack | wr_ack;
      tick();
      if (!busy_prev && (rd_ack || wr_ack)) begin
        kind = wr_ack ? 1 : 0;
        return;
      end
    end
  endtask

  initial begin
    int kind;
    int acks;
    int exp_seq [11] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 0, 0};

    rd_data = '0;
    wr_data = '0;
    wr_ecc  = '0;
    do_reset();

    check("rst_req",   jbi_sctag_req, 32'h0);
    check("rst_vld",   32'(jbi_sctag_req_vld), 32'h0);
    check("rst_ecc",   32'(jbi_scbuf_ecc), 32'h0);
    check("rst_err",   32'(cred_err), 32'h0);
    check("rst_rdack", 32'(rd_ack), 32'h0);
    check("rst_wrack", 32'(wr_ack), 32'h0);
    check("rst_iq",    32'(dut.iq_cred), 32'd16);
    check("rst_wib",   32'(dut.wib_cred), 32'd4);

    // Single read
    rd_vld  = 1'b1;
    rd_data = 32'hA000_0001;
    tick();
    rd_vld = 1'b0;
    check("rd_ack_b0", 32'(rd_ack), 32'h1);
    check("rd_vld_t1", 32'(jbi_sctag_req_vld), 32'h0);
    check("rd_iq",     32'(dut.iq_cred), 32'd15);
    tick();
    check("rd_req0",   jbi_sctag_req, 32'hA000_0001);
    check("rd_vld0",   32'(jbi_sctag_req_vld), 32'h1);
    check("rd_ecc0",   32'(jbi_scbuf_ecc), 32'h0);
    check("rd_ack_b1", 32'(rd_ack), 32'h1);
    rd_data = 32'h0000_1000;
    tick();
    check("rd_req1",   jbi_sctag_req, 32'h0000_1000);
    check("rd_vld1",   32'(jbi_sctag_req_vld), 32'h0);
    check("rd_ecc1",   32'(jbi_scbuf_ecc), 32'h0);
    check("rd_ack_end", 32'(rd_ack), 32'h0);

    // Single write
    wr_vld = 1'b1;
    tick();
    wr_vld = 1'b0;
    acks = 0;
    for (int i = 0; i < 18; i++) begin
      if (wr_ack) acks++;
      wr_data = 32'hB000_0000 + i;
      wr_ecc  = 7'h55;
      tick();
      check("wr_req", jbi_sctag_req, 32'hB000_0000 + i);
      check("wr_vld", 32'(jbi_sctag_req_vld), (i == 0) ? 32'h1 : 32'h0);
      check("wr_ecc", 32'(jbi_scbuf_ecc), (i >= 2) ? 32'h55 : 32'h0);
    end
    check("wr_ack_end", 32'(wr_ack), 32'h0);
    check("wr_ack_cnt", 32'(acks), 32'd18);
    check("wr_wib",     32'(dut.wib_cred), 32'd3);
    check("wr_iq",      32'(dut.iq_cred), 32'd14);

    // Contention and WIB exhaustion
    do_reset();
    rd_vld = 1'b1;
    wr_vld = 1'b1;
    for (int g = 0; g < 11; g++) begin
      next_grant(kind);
      check("cont_seq", 32'(kind), 32'(exp_seq[g]));
    end
    check("cont_wib0", 32'(dut.wib_cred), 32'd0);
    sctag_jbi_wib_dequeue = 1'b1;
    tick();
    sctag_jbi_wib_dequeue = 1'b0;
    next_grant(kind);
    check("cont_wib_ret", 32'(kind), 32'd1);
    next_grant(kind);
    check("cont_after", 32'(kind), 32'd0);
    rd_vld = 1'b0;
    wr_vld = 1'b0;

    // IQ credit exhaustion
    do_reset();
    rd_vld = 1'b1;
    for (int g = 0; g < 16; g++) begin
      next_grant(kind);
      check("iq_rd", 32'(kind), 32'd0);
    end
    check("iq_zero", 32'(dut.iq_cred), 32'd0);
    next_grant(kind);
    check("iq_stall", 32'(kind), 32'd2);
    sctag_jbi_iq_dequeue = 1'b1;
    tick();
    sctag_jbi_iq_dequeue = 1'b0;
    next_grant(kind);
    check("iq_one_more", 32'(kind), 32'd0);
    next_grant(kind);
    check("iq_stall2", 32'(kind), 32'd2);
    rd_vld = 1'b0;
    sctag_jbi_iq_dequeue = 1'b1;
    tick();
    sctag_jbi_iq_dequeue = 1'b0;
    check("iq_ret1", 32'(dut.iq_cred), 32'd1);
    rd_vld = 1'b1;
    sctag_jbi_iq_dequeue = 1'b1;
    tick();
    rd_vld = 1'b0;
    sctag_jbi_iq_dequeue = 1'b0;
    check("iq_same_ack", 32'(rd_ack), 32'h1);
    check("iq_same_cnt", 32'(dut.iq_cred), 32'd1);
    tick();
    tick();

    // Overflow, then reset mid-write
    do_reset();
    sctag_jbi_iq_dequeue = 1'b1;
    tick();
    sctag_jbi_iq_dequeue = 1'b0;
    check("ovf_err", 32'(cred_err), 32'h1);
    check("ovf_iq",  32'(dut.iq_cred), 32'd16);
    tick();
    check("ovf_sticky", 32'(cred_err), 32'h1);

    wr_vld  = 1'b1;
    wr_data = 32'hC0DE_0000;
    wr_ecc  = 7'h55;
    tick();
    wr_vld = 1'b0;
    repeat (7) tick();
    check("mid_wrack", 32'(wr_ack), 32'h1);
    check("mid_ecc",   32'(jbi_scbuf_ecc), 32'h55);
    rst = 1'b1;
    #1;
    check("ar_wrack", 32'(wr_ack), 32'h0);
    check("ar_rdack", 32'(rd_ack), 32'h0);
    check("ar_req",   jbi_sctag_req, 32'h0);
    check("ar_vld",   32'(jbi_sctag_req_vld), 32'h0);
    check("ar_ecc",   32'(jbi_scbuf_ecc), 32'h0);
    check("ar_err",   32'(cred_err), 32'h0);
    check("ar_iq",    32'(dut.iq_cred), 32'd16);
    check("ar_wib",   32'(dut.wib_cred), 32'd4);
    tick();
    rst = 1'b0;

`ifdef JBI_SC_ARB_PERF_EN
    do_reset();
    rd_vld = 1'b1;
    for (int g = 0; g < 3; g++) next_grant(kind);
    rd_vld = 1'b0;
    wr_vld = 1'b1;
    for (int g = 0; g < 2; g++) next_grant(kind);
    wr_vld = 1'b0;
    repeat (20) tick();
    check("perf_rd", 32'(perf_rd_cnt), 32'd3);
    check("perf_wr", 32'(perf_wr_cnt), 32'd2);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
